// File: rtl/c4_move_controller.sv
// Connect-4 move sequencer: finds the landing row for a requested column, places the piece,
// scans four directions for a run of WIN_LEN, and tracks win/draw/turn state.
module c4_move_controller #(
    parameter int unsigned WIN_LEN      = 4,
    parameter logic        FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [2:0]  move_col,
    output logic        move_ready,
    output logic        move_reject,
    output logic [41:0] red_board,
    output logic [41:0] yellow_board,
    output logic        turn,
    output logic [5:0]  last_idx,
    output logic [1:0]  winner,
    output logic        game_over
);

    typedef enum logic [2:0] {IDLE, SCAN, PLACE, CHECK, FINISH, OVER} state_t;

    state_t      state_q, state_d;
    logic [2:0]  col_q, col_d;
    logic [2:0]  row_q, row_d;
    logic [1:0]  dir_q, dir_d;
    logic        win_q, win_d;
    logic [5:0]  count_q, count_d;
    logic [41:0] red_q, red_d;
    logic [41:0] yel_q, yel_d;
    logic        turn_q, turn_d;
    logic [5:0]  last_q, last_d;
    logic [1:0]  winner_q, winner_d;
    logic        over_q, over_d;
    logic        ready_q, ready_d;
    logic        reject_q, reject_d;

    logic [41:0] occ;
    logic [41:0] mine;
    logic [5:0]  cell_idx;
    int          dc, dr;
    logic [2:0]  fwd_len, bwd_len;
    logic        dir_win;

    // Counts same-colour cells stepping away from (c0,r0); stops at the first gap or board edge.
    function automatic logic [2:0] run_len(input logic [41:0] b, input int c0, input int r0,
                                           input int sc, input int sr);
        logic [2:0] n;
        logic       go;
        int         c, r;
        logic [5:0] idx;
        n  = '0;
        go = 1'b1;
        for (int unsigned k = 1; k < WIN_LEN; k++) begin
            c   = c0 + int'(k) * sc;
            r   = r0 + int'(k) * sr;
            idx = 6'(c + 7 * r);
            if (go && c >= 0 && c < 7 && r >= 0 && r < 6 && b[idx]) begin
                n = n + 3'd1;
            end else begin
                go = 1'b0;
            end
        end
        return n;
    endfunction

    assign occ      = red_q | yel_q;
    assign mine     = turn_q ? yel_q : red_q;
    assign cell_idx = {3'b000, col_q} + 6'(row_q) * 6'd7;

    always_comb begin
        dc = 0;
        dr = 0;
        case (dir_q)
            2'd0: begin dc = 1;  dr = 0; end
            2'd1: begin dc = 0;  dr = 1; end
            2'd2: begin dc = 1;  dr = 1; end
            default: begin dc = -1; dr = 1; end
        endcase
        fwd_len = run_len(mine, int'(col_q), int'(row_q), dc, dr);
        bwd_len = run_len(mine, int'(col_q), int'(row_q), -dc, -dr);
        dir_win = (32'(fwd_len) + 32'(bwd_len) + 32'd1) >= WIN_LEN;
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        dir_d    = dir_q;
        win_d    = win_q;
        count_d  = count_q;
        red_d    = red_q;
        yel_d    = yel_q;
        turn_d   = turn_q;
        last_d   = last_q;
        winner_d = winner_q;
        reject_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (move_valid) begin
                    if (move_col > 3'd6 || occ[{3'b000, move_col}]) begin
                        reject_d = 1'b1;
                    end else begin
                        col_d   = move_col;
                        row_d   = 3'd5;
                        win_d   = 1'b0;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!occ[cell_idx]) begin
                    state_d = PLACE;
                end else begin
                    row_d = row_q - 3'd1;
                end
            end
            PLACE: begin
                if (turn_q) begin
                    yel_d[cell_idx] = 1'b1;
                end else begin
                    red_d[cell_idx] = 1'b1;
                end
                last_d  = cell_idx;
                count_d = count_q + 6'd1;
                dir_d   = 2'd0;
                state_d = CHECK;
            end
            CHECK: begin
                if (dir_win) begin
                    win_d = 1'b1;
                end
                dir_d = dir_q + 2'd1;
                if (dir_q == 2'd3) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (win_q) begin
                    winner_d = turn_q ? 2'd2 : 2'd1;
                    state_d  = OVER;
                end else if (count_q == 6'd42) begin
                    winner_d = 2'd3;
                    state_d  = OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = IDLE;
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // new_game overrides whatever the FSM computed, including a half-finished placement.
        if (new_game) begin
            state_d  = IDLE;
            col_d    = '0;
            row_d    = '0;
            dir_d    = '0;
            win_d    = 1'b0;
            count_d  = '0;
            red_d    = '0;
            yel_d    = '0;
            turn_d   = FIRST_PLAYER;
            last_d   = '1;
            winner_d = '0;
            reject_d = 1'b0;
        end

        ready_d = (state_d == IDLE);
        over_d  = (winner_d != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            dir_q    <= '0;
            win_q    <= 1'b0;
            count_q  <= '0;
            red_q    <= '0;
            yel_q    <= '0;
            turn_q   <= FIRST_PLAYER;
            last_q   <= '1;
            winner_q <= '0;
            over_q   <= 1'b0;
            ready_q  <= 1'b1;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            count_q  <= count_d;
            red_q    <= red_d;
            yel_q    <= yel_d;
            turn_q   <= turn_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            over_q   <= over_d;
            ready_q  <= ready_d;
            reject_q <= reject_d;
        end
    end

    assign move_ready   = ready_q;
    assign move_reject  = reject_q;
    assign red_board    = red_q;
    assign yellow_board = yel_q;
    assign turn         = turn_q;
    assign last_idx     = last_q;
    assign winner       = winner_q;
    assign game_over    = over_q;

endmodule
